// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//  Shares the register file's single write port between the main pipeline
//  writeback (port A) and a long-latency unit (port B). Port A normally wins,
//  but port B is forced through after STARVE_LIMIT consecutive denied cycles.
//  A 32-entry pending scoreboard tracks destinations issued to port B so the
//  hazard unit can stall on busy registers.
//
// Ports
//  clk, rst                 clock, synchronous active-high reset
//  a_valid/a_addr/a_data    pipeline writeback request; a_ready = granted
//  b_valid/b_addr/b_data    long-latency writeback request; b_ready = granted
//  iss_valid/iss_addr       dispatch of an op to the long-latency unit
//  rs1_q/rs2_q/rd_q         hazard queries -> rs1_busy/rs2_busy/rd_busy
//  wr_en/wr_addr/wr_data    register file write port
//  waw_err                  sticky protocol-violation flag
module regfile_wb_arbiter #(
  parameter int N            = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [4:0]   b_addr,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  input  logic         iss_valid,
  input  logic [4:0]   iss_addr,
  input  logic [4:0]   rs1_q,
  input  logic [4:0]   rs2_q,
  input  logic [4:0]   rd_q,
  output logic         rs1_busy,
  output logic         rs2_busy,
  output logic         rd_busy,
  output logic         wr_en,
  output logic [4:0]   wr_addr,
  output logic [N-1:0] wr_data,
  output logic         waw_err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic [CW-1:0] starve_cnt;
  logic          force_b;
  logic          grant_a;
  logic          grant_b;
  logic          iss_set;
  logic          err_now;

  assign force_b = (starve_cnt >= LIMIT_C);

  // Arbitration and write-port mux; everything is held quiet during reset
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = '0;
    if (!rst) begin
      if (a_valid && !(b_valid && force_b)) begin
        grant_a = 1'b1;
        wr_en   = (a_addr != 5'd0);
        wr_addr = a_addr;
        wr_data = a_data;
      end else if (b_valid) begin
        grant_b = 1'b1;
        wr_en   = (b_addr != 5'd0);
        wr_addr = b_addr;
        wr_data = b_data;
      end else begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next scoreboard state and protocol-violation detection
  always_comb begin
    iss_set     = iss_valid && (iss_addr != 5'd0);
    pending_nxt = pending;
    err_now     = 1'b0;
    if (grant_b) begin
      pending_nxt[b_addr] = 1'b0;
    end else begin
      pending_nxt = pending_nxt;
    end
    // A set issued in the same cycle as the clear wins: a new op is in flight
    if (iss_set) begin
      pending_nxt[iss_addr] = 1'b1;
    end else begin
      pending_nxt = pending_nxt;
    end
    pending_nxt[0] = 1'b0;

    if (iss_set && pending[iss_addr] && !(grant_b && (b_addr == iss_addr))) begin
      err_now = 1'b1;
    end else if (grant_a && pending[a_addr]) begin
      err_now = 1'b1;
    end else if (grant_b && !pending[b_addr]) begin
      err_now = 1'b1;
    end else begin
      err_now = 1'b0;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Starvation counter: counts consecutive denied B cycles, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!b_valid || grant_b) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT_C) begin
      starve_cnt <= starve_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Sticky violation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      waw_err <= 1'b0;
    end else if (err_now) begin
      waw_err <= 1'b1;
    end else begin
      waw_err <= waw_err;
    end
  end

  assign rs1_busy = pending[rs1_q];
  assign rs2_busy = pending[rs2_q];
  assign rd_busy  = pending[rd_q];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr, rs1_q, rs2_q, rd_q;
  logic [31:0] a_data, b_data, wr_data;
  logic        a_ready, b_ready, rs1_busy, rs2_busy, rd_busy, wr_en, waw_err;
  logic [4:0]  wr_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rd_q(rd_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .waw_err(waw_err)
  );

  // Output bundle: {a_ready, b_ready, wr_en, wr_addr, wr_data, rs1_busy, rs2_busy, rd_busy, waw_err}
  typedef struct {
    string       name;
    bit          rst;
    bit          av;
    bit [4:0]    aa;
    bit [31:0]   ad;
    bit          bv;
    bit [4:0]    ba;
    bit [31:0]   bd;
    bit          iv;
    bit [4:0]    ia;
    bit [4:0]    q1, q2, qd;
    logic [43:0] exp;
  } vec_t;

  function automatic logic [43:0] eo(bit ar, bit br, bit we, bit [4:0] wa, bit [31:0] wd,
                                     bit b1, bit b2, bit b3, bit err);
    return {ar, br, we, wa, wd, b1, b2, b3, err};
  endfunction

  function automatic vec_t mk(string nm, bit r, bit av, bit [4:0] aa, bit [31:0] ad,
                              bit bv, bit [4:0] ba, bit [31:0] bd, bit iv, bit [4:0] ia,
                              bit [4:0] q1, bit [4:0] q2, bit [4:0] qd, logic [43:0] exp);
    vec_t v;
    v.name = nm; v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba;
    v.bd = bd; v.iv = iv; v.ia = ia; v.q1 = q1; v.q2 = q2; v.qd = qd; v.exp = exp;
    return v;
  endfunction

  task automatic drive(bit r, bit av, bit [4:0] aa, bit [31:0] ad, bit bv, bit [4:0] ba,
                       bit [31:0] bd, bit iv, bit [4:0] ia, bit [4:0] q1, bit [4:0] q2,
                       bit [4:0] qd);
    rst = r; a_valid = av; a_addr = aa; a_data = ad; b_valid = bv; b_addr = ba;
    b_data = bd; iss_valid = iv; iss_addr = ia; rs1_q = q1; rs2_q = q2; rd_q = qd;
  endtask

  task automatic check(string nm, logic [43:0] exp);
    logic [43:0] act;
    act = {a_ready, b_ready, wr_en, wr_addr, wr_data, rs1_busy, rs2_busy, rd_busy, waw_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ar=%b br=%b we=%b wa=%0d wd=%h busy=%b%b%b err=%b, want ar=%b br=%b we=%b wa=%0d wd=%h busy=%b%b%b err=%b",
               nm, act[43], act[42], act[41], act[40:36], act[35:4], act[3], act[2], act[1], act[0],
               exp[43], exp[42], exp[41], exp[40:36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive at negedge, sample 1 time unit later, well before the next posedge
  task automatic step(bit r, bit av, bit [4:0] aa, bit [31:0] ad, bit bv, bit [4:0] ba,
                      bit [31:0] bd, bit iv, bit [4:0] ia, bit [4:0] q1, bit [4:0] q2,
                      bit [4:0] qd, string nm, logic [43:0] exp);
    @(negedge clk);
    drive(r, av, aa, ad, bv, ba, bd, iv, ia, q1, q2, qd);
    #1;
    check(nm, exp);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = mk("rst_cyc0", 1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 5'd0, 5'd5, 5'd9, 5'd7,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    tbl[1] = mk("rst_cyc1", 1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 5'd0, 5'd5, 5'd9, 5'd7,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    tbl[2] = mk("issue_x5", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd9, 5'd7,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    tbl[3] = mk("b_write_x5", 0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd9, 5'd7,
                eo(0, 1, 1, 5'd5, 32'hDEADBEEF, 1, 0, 0, 0));
    tbl[4] = mk("x5_released", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd9, 5'd7,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    tbl[5] = mk("a_write_x0", 0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, 1, 5'd0, 5'd5, 5'd9, 5'd0,
                eo(1, 0, 0, 5'd0, 32'h1234, 0, 0, 0, 0));
    tbl[6] = mk("x0_not_pending", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd9, 5'd0,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    tbl[7] = mk("issue_x9", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd5, 5'd9, 5'd7,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    tbl[8] = mk("b9_and_iss9", 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd5, 5'd9, 5'd7,
                eo(0, 1, 1, 5'd9, 32'h99, 0, 1, 0, 0));
    tbl[9] = mk("x9_still_pending", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd9, 5'd7,
                eo(0, 0, 0, 5'd0, 32'h0, 0, 1, 0, 0));

    // Establish known state before the first checked vector
    drive(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 5'd0, 5'd5, 5'd9, 5'd7);
    @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
           tbl[i].iv, tbl[i].ia, tbl[i].q1, tbl[i].q2, tbl[i].qd, tbl[i].name, tbl[i].exp);
    end

    // Starvation: A hogs the port, B is denied four cycles then forced through
    step(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd3, 5'd0, "starve_issue_x7",
         eo(1, 0, 1, 5'd3, 32'h33, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 5'd0, 5'd7, 5'd3, 5'd0,
           $sformatf("starve_deny%0d", i + 1), eo(1, 0, 1, 5'd3, 32'h33, 1, 0, 0, 0));
    end
    step(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 5'd0, 5'd7, 5'd3, 5'd0, "starve_force_b",
         eo(0, 1, 1, 5'd7, 32'h77, 1, 0, 0, 0));
    step(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd3, 5'd0, "starve_a_resumes",
         eo(1, 0, 1, 5'd3, 32'h33, 0, 0, 0, 0));

    // Violation: double issue of x4
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 5'd4, 5'd3, 5'd0, "viol_issue_x4",
         eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 5'd4, 5'd3, 5'd0, "viol_reissue_x4",
         eo(0, 0, 0, 5'd0, 32'h0, 1, 0, 0, 0));
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd3, 5'd0, "viol_double_issue_flag",
         eo(0, 0, 0, 5'd0, 32'h0, 1, 0, 0, 1));
    // Reset mid-operation: request held but dropped, flag/scoreboard cleared at the edge
    step(1, 1, 5'd4, 32'h44, 1, 5'd4, 32'h44, 1, 5'd4, 5'd4, 5'd3, 5'd0, "viol_rst_hold",
         eo(0, 0, 0, 5'd0, 32'h0, 1, 0, 0, 1));
    // Violation: A writes a pending register; write still performed
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd6, 5'd6, 5'd4, 5'd0, "viol_after_rst",
         eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
    step(0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 5'd0, 5'd6, 5'd4, 5'd0, "viol_a_to_pending",
         eo(1, 0, 1, 5'd6, 32'h66, 1, 0, 0, 0));
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd6, 5'd4, 5'd0, "viol_a_pending_flag",
         eo(0, 0, 0, 5'd0, 32'h0, 1, 0, 0, 1));
    // Violation: B handshake to a register that is not pending
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd4, 5'd0, "viol_rst2",
         eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 1));
    step(0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h88, 0, 5'd0, 5'd8, 5'd6, 5'd0, "viol_b_unpending",
         eo(0, 1, 1, 5'd8, 32'h88, 0, 0, 0, 0));
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd6, 5'd0, "viol_b_unpending_flag",
         eo(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
